// File: rtl/shift_add_mul_ctrl.sv
// Sequencer for the shift-and-add multiplier: drives A/B shift-register ops and accumulator strobes.
// Moore FSM, outputs from state only; SHIFT_ADD_EARLY_EXIT_EN ends the run when B becomes zero.
module shift_add_mul_ctrl #(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic             b_lsb,
  input  logic             b_zero,
  output logic [1:0]       a_op,
  output logic [1:0]       b_op,
  output logic             acc_clr,
  output logic             add_en,
  output logic [CNT_W-1:0] iter,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_TEST,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;
  logic   last_iter;

  assign last_iter = (iter == LAST_ITER);

  always_ff @(posedge Clk) begin
    if (reset) begin
      state <= S_IDLE;
      iter  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR) begin
        iter <= '0;
      end else if (state == S_SHIFT && !last_iter) begin
        iter <= iter + CNT_W'(1);
      end
    end
  end

`ifdef SHIFT_ADD_EARLY_EXIT_EN
  logic b_exhausted;
  assign b_exhausted = b_zero;
`else
  logic b_exhausted;
  logic unused_b_zero;
  assign b_exhausted   = 1'b0;
  assign unused_b_zero = b_zero;
`endif

  always_comb begin
    state_nxt = state;
    a_op      = OP_HOLD;
    b_op      = OP_HOLD;
    acc_clr   = 1'b0;
    add_en    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        a_op      = OP_CLEAR;
        b_op      = OP_CLEAR;
        acc_clr   = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        a_op      = OP_LOAD;
        b_op      = OP_LOAD;
        state_nxt = S_TEST;
      end
      S_TEST: begin
        // An empty B register means no partial products remain.
        if (b_exhausted)  state_nxt = S_DONE;
        else if (b_lsb)   state_nxt = S_ADD;
        else              state_nxt = S_SHIFT;
      end
      S_ADD: begin
        add_en    = 1'b1;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        a_op      = OP_SHIFT;
        b_op      = OP_SHIFT;
        state_nxt = last_iter ? S_DONE : S_TEST;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Scoreboard bench: a small datapath model closes the loop; expected products and timing come from arithmetic.
module tb_shift_add_mul_ctrl;
  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH);

  logic             Clk = 1'b0;
  logic             reset, start, b_lsb, b_zero;
  logic [1:0]       a_op, b_op;
  logic             acc_clr, add_en, busy, done;
  logic [CNT_W-1:0] iter;

  always #5 Clk = ~Clk;

  shift_add_mul_ctrl #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .reset(reset), .start(start), .b_lsb(b_lsb), .b_zero(b_zero),
    .a_op(a_op), .b_op(b_op), .acc_clr(acc_clr), .add_en(add_en),
    .iter(iter), .busy(busy), .done(done)
  );

  // Datapath model reacting to the op codes
  logic [2*WIDTH-1:0] a_reg = '0, acc = '0;
  logic [WIDTH-1:0]   b_reg = '0;
  logic [WIDTH-1:0]   a_in = '0, b_in = '0;
  int                 cyc = 0;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    case (a_op)
      2'b01:   a_reg <= '0;
      2'b10:   a_reg <= {{WIDTH{1'b0}}, a_in};
      2'b11:   a_reg <= a_reg << 1;
      default: a_reg <= a_reg;
    endcase
    case (b_op)
      2'b01:   b_reg <= '0;
      2'b10:   b_reg <= b_in;
      2'b11:   b_reg <= b_reg >> 1;
      default: b_reg <= b_reg;
    endcase
    if (acc_clr)     acc <= '0;
    else if (add_en) acc <= acc + a_reg;
  end

  assign b_lsb  = b_reg[0];
  assign b_zero = (b_reg == '0);

  typedef struct {
    int prod;
    int lat;
    int done_cyc;
    int it;
    int adds;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: product by multiplication, timing from bit counts of B
  function automatic exp_t model(input int a, input int b, input int e);
    exp_t x;
    int   pop = 0;
    int   msb = -1;
    for (int i = 0; i < WIDTH; i++) begin
      if (((b >> i) & 1) == 1) begin
        pop++;
        msb = i;
      end
    end
    x.prod = a * b;
    x.adds = pop;
    x.lat  = 3 + 2 * WIDTH + pop;
    x.it   = WIDTH - 1;
`ifdef SHIFT_ADD_EARLY_EXIT_EN
    if (b == 0) begin
      x.lat = 4;
      x.it  = 0;
    end else if (msb < WIDTH - 1) begin
      x.lat = 4 + 2 * (msb + 1) + pop;
      x.it  = msb + 1;
    end
`endif
    x.done_cyc = e + x.lat - 1;
    return x;
  endfunction

  // Monitor
  int busy_run = 0;
  int add_cnt  = 0;
  bit after_done = 1'b0;

  always @(negedge Clk) begin
    if (add_en && (a_op == 2'b11 || b_op == 2'b11)) chk("add_with_shift", 1, 0);
    if (after_done) begin
      chk("idle_after_done", int'(busy), 0);
      after_done = 1'b0;
    end
    if (!busy) begin
      busy_run = 0;
      add_cnt  = 0;
    end else begin
      busy_run++;
      if (add_en) add_cnt++;
    end
    if (done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        chk("done_cycle", cyc, x.done_cyc);
        chk("product", int'(acc), x.prod);
        chk("iter_at_done", int'(iter), x.it);
        chk("busy_cycles", busy_run, x.lat);
        chk("add_count", add_cnt, x.adds);
      end
      after_done = 1'b1;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (busy) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(negedge Clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_a_op"}, int'(a_op), 0);
    chk({tag, "_b_op"}, int'(b_op), 0);
    chk({tag, "_acc_clr"}, int'(acc_clr), 0);
    chk({tag, "_add_en"}, int'(add_en), 0);
    chk({tag, "_iter"}, int'(iter), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  task automatic run_one(input int a, input int b, input int pulses);
    wait_idle();
    a_in  = WIDTH'(a);
    b_in  = WIDTH'(b);
    start = 1'b1;
    sbq.push_back(model(a, b, cyc + 1));
    @(negedge Clk);
    start = 1'b0;
    for (int k = 0; k < pulses; k++) begin
      @(negedge Clk);
      if (busy && !done) start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
    end
    wait_drain();
  endtask

  initial begin
    int e, e_last, n;
    exp_t x;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge Clk);

    run_one(3, 0, 0);
    run_one(3, 15, 0);
    run_one(6, 5, 0);
    run_one(9, 1, 0);
    run_one(15, 8, 2);

    // Abort in an ADD cycle
    wait_idle();
    a_in  = WIDTH'(5);
    b_in  = WIDTH'(15);
    start = 1'b1;
    sbq.push_back(model(5, 15, cyc + 1));
    @(negedge Clk);
    start = 1'b0;
    n = 0;
    while (!add_en && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("reached_add", int'(add_en), 1);
    reset = 1'b1;
    void'(sbq.pop_back());
    @(negedge Clk);
    check_idle_outputs("midreset");
    reset = 1'b0;
    repeat (3) @(negedge Clk);
    run_one(7, 11, 0);

    // Start held high: back-to-back runs
    wait_idle();
    a_in  = WIDTH'(13);
    b_in  = WIDTH'(6);
    e     = cyc + 1;
    e_last = e;
    start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      x = model(13, 6, e);
      sbq.push_back(x);
      e_last = e;
      e = e + x.lat + 1;
    end
    n = 0;
    while (cyc < e_last && n < 200) begin
      @(negedge Clk);
      n++;
    end
    start = 1'b0;
    wait_drain();

    for (int r = 0; r < 20; r++) begin
      run_one(int'($urandom_range(0, (1 << WIDTH) - 1)),
              int'($urandom_range(0, (1 << WIDTH) - 1)),
              int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge Clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
